// File: rtl/poker_pkg.sv
// rtl/poker_pkg.sv - shared ranks, categories, score layout and scan helpers
// Used by the hand evaluator top level and its rank-scan datapath.
package poker_pkg;

  localparam logic [3:0] RANK_MIN      = 4'd2;
  localparam logic [3:0] RANK_MAX      = 4'd14;
  localparam logic [3:0] RANK_WHEEL_HI = 4'd5;
  localparam int         NUM_RANKS     = 13;
  localparam int         ACE_IDX       = NUM_RANKS - 1;

  localparam logic [1:0] SUIT_C = 2'd0;
  localparam logic [1:0] SUIT_H = 2'd1;
  localparam logic [1:0] SUIT_S = 2'd2;
  localparam logic [1:0] SUIT_D = 2'd3;

  localparam logic [3:0] CAT_HIGH     = 4'd0;
  localparam logic [3:0] CAT_PAIR     = 4'd1;
  localparam logic [3:0] CAT_TWO_PAIR = 4'd2;
  localparam logic [3:0] CAT_TRIPS    = 4'd3;
  localparam logic [3:0] CAT_STRAIGHT = 4'd4;
  localparam logic [3:0] CAT_FLUSH    = 4'd5;
  localparam logic [3:0] CAT_FULL     = 4'd6;
  localparam logic [3:0] CAT_QUADS    = 4'd7;
  localparam logic [3:0] CAT_SF       = 4'd8;

  localparam int SCORE_W       = 24;
  localparam int SCORE_CAT_LSB = 20;
  localparam int SCORE_K0_LSB  = 16;
  localparam int KICKER_W      = 4;

  typedef struct packed {
    logic [1:0] suit;
    logic [3:0] rank;
  } card_t;

  // Element 0 holds the highest rank; unused slots stay zero.
  typedef logic [4:0][3:0] rank5_t;

  typedef struct packed {
    logic [2:0]      run_any;
    logic [3:0][2:0] run_s;
    logic [3:0]      st_hi;
    logic [3:0]      sf_hi;
    logic [2:0]      n_all;
    rank5_t          top_all;
    logic [3:0][2:0] n_s;
    rank5_t [3:0]    top_s;
    logic [3:0]      quad_r;
    logic [3:0]      trip_hi;
    logic [3:0]      trip_lo;
    logic [3:0]      pair_hi;
    logic [3:0]      pair_lo;
  } scan_state_t;

  function automatic logic [2:0] run_next(input logic [2:0] run, input logic present);
    if (!present) return 3'd0;
    return (run == 3'd5) ? 3'd5 : run + 3'd1;
  endfunction

  function automatic logic [2:0] pop5(input logic [4:0] v);
    return {2'b0, v[0]} + {2'b0, v[1]} + {2'b0, v[2]} + {2'b0, v[3]} + {2'b0, v[4]};
  endfunction

  // Compacts the descending rank list with up to two ranks removed.
  function automatic rank5_t drop_ranks(input rank5_t top, input logic [3:0] ea,
                                        input logic [3:0] eb);
    rank5_t res;
    int     j;
    res = '0;
    j   = 0;
    for (int i = 0; i < 5; i++) begin
      if (top[i] != 4'd0 && top[i] != ea && top[i] != eb) begin
        res[j] = top[i];
        j++;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/hand_rank_scan.sv
// rtl/hand_rank_scan.sv - per-rank scan datapath, one rank column per step
// Ranks arrive Ace-to-Two, so every "first seen" record is already the highest.
module hand_rank_scan
  import poker_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        step,
  input  logic [3:0]  rank,
  input  logic [3:0]  col,
  output scan_state_t st
);

  scan_state_t nxt;
  logic        any;
  logic [2:0]  cnt;

  always_comb begin
    nxt = st;
    any = |col;
    cnt = {2'b0, col[0]} + {2'b0, col[1]} + {2'b0, col[2]} + {2'b0, col[3]};
    if (step) begin
      nxt.run_any = run_next(st.run_any, any);
      if (any && st.run_any >= 3'd4 && st.st_hi == 4'd0)
        nxt.st_hi = rank + 4'd4;
      if (any && st.n_all < 3'd5) begin
        nxt.top_all[st.n_all] = rank;
        nxt.n_all             = st.n_all + 3'd1;
      end
      for (int s = 0; s < 4; s++) begin
        nxt.run_s[s] = run_next(st.run_s[s], col[s]);
        if (col[s] && st.run_s[s] >= 3'd4 && st.sf_hi == 4'd0)
          nxt.sf_hi = rank + 4'd4;
        if (col[s] && st.n_s[s] < 3'd5) begin
          nxt.top_s[s][st.n_s[s]] = rank;
          nxt.n_s[s]              = st.n_s[s] + 3'd1;
        end
      end
      // Exact counts keep trips out of the pair slots and quads out of both.
      case (cnt)
        3'd4: if (st.quad_r == 4'd0) nxt.quad_r = rank;
        3'd3: begin
          if (st.trip_hi == 4'd0)      nxt.trip_hi = rank;
          else if (st.trip_lo == 4'd0) nxt.trip_lo = rank;
        end
        3'd2: begin
          if (st.pair_hi == 4'd0)      nxt.pair_hi = rank;
          else if (st.pair_lo == 4'd0) nxt.pair_lo = rank;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   st <= '0;
    else if (clear) st <= '0;
    else            st <= nxt;
  end

endmodule

// File: rtl/hand_evaluator.sv
// rtl/hand_evaluator.sv - sequential poker hand evaluator producing a 24-bit ordered score
// Loads cards into a suit/rank matrix, scans ranks, then classifies in one final cycle.
module hand_evaluator
  import poker_pkg::*;
#(
  parameter int NUM_CARDS = 7,
  parameter int CARD_W    = 6
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        start,
  input  logic [NUM_CARDS*CARD_W-1:0] cards,
  output logic                        busy,
  output logic                        done,
  output logic [SCORE_W-1:0]          score,
  output logic                        flush_draw,
  output logic                        straight_draw,
  output logic                        dup_err
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SCAN, S_FINAL, S_DONE} state_t;

  state_t                        state_q, state_n;
  logic [NUM_CARDS*CARD_W-1:0]   cards_q;
  logic [3:0]                    load_cnt;
  logic [3:0]                    scan_rank;
  logic [3:0][NUM_RANKS-1:0]     mat;
  logic [3:0][3:0]               suit_cnt;
  logic                          dup_q;
  logic                          done_q;

  card_t                         cur;
  logic                          cur_ok;
  logic [3:0]                    cur_idx;
  logic [3:0]                    scan_idx;
  logic [3:0]                    col;
  logic                          accept;
  scan_state_t                   sc;

  assign accept   = (state_q == S_IDLE) && start;
  assign cur      = card_t'(cards_q[5:0]);
  assign cur_ok   = (cur.rank >= RANK_MIN) && (cur.rank <= RANK_MAX);
  assign cur_idx  = cur.rank - RANK_MIN;
  assign scan_idx = scan_rank - RANK_MIN;
  assign done     = done_q;

  always_comb begin
    col = '0;
    for (int s = 0; s < 4; s++) col[s] = mat[s][scan_idx];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    busy    = (state_q != S_IDLE);
    case (state_q)
      S_IDLE:  if (start) state_n = S_LOAD;
      S_LOAD:  if (load_cnt == 4'(NUM_CARDS - 1)) state_n = S_SCAN;
      S_SCAN:  if (scan_rank == RANK_MIN) state_n = S_FINAL;
      S_FINAL: state_n = S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Cards shift down so slot 0 is always the one being loaded.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cards_q   <= '0;
      load_cnt  <= '0;
      scan_rank <= '0;
      mat       <= '0;
      suit_cnt  <= '0;
      dup_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          cards_q   <= cards;
          load_cnt  <= '0;
          scan_rank <= RANK_MAX;
          mat       <= '0;
          suit_cnt  <= '0;
          dup_q     <= 1'b0;
        end
        S_LOAD: begin
          cards_q  <= cards_q >> CARD_W;
          load_cnt <= load_cnt + 4'd1;
          if (cur_ok) begin
            if (mat[cur.suit][cur_idx]) begin
              dup_q <= 1'b1;
            end else begin
              mat[cur.suit][cur_idx] <= 1'b1;
              suit_cnt[cur.suit]     <= suit_cnt[cur.suit] + 4'd1;
            end
          end
        end
        S_SCAN: scan_rank <= scan_rank - 4'd1;
        default: ;
      endcase
    end
  end

  hand_rank_scan u_scan (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (accept),
    .step    (state_q == S_SCAN),
    .rank    (scan_rank),
    .col     (col),
    .st      (sc)
  );

  logic [NUM_RANKS-1:0] pres;
  logic [3:0]           straight_hi, sf_top, cat;
  logic                 flush_hit, near_flush, near_straight;
  logic [1:0]           flush_suit;
  rank5_t               kick, rest;
  logic [SCORE_W-1:0]   score_n;
  logic                 fd_n, sd_n;

  always_comb begin
    pres        = mat[0] | mat[1] | mat[2] | mat[3];
    straight_hi = sc.st_hi;
    // A run still open at the Two with four ranks means 5-4-3-2; the Ace closes the wheel.
    if (straight_hi == 4'd0 && pres[ACE_IDX] && sc.run_any >= 3'd4)
      straight_hi = RANK_WHEEL_HI;
    sf_top = sc.sf_hi;
    for (int s = 0; s < 4; s++)
      if (sf_top == 4'd0 && mat[s][ACE_IDX] && sc.run_s[s] >= 3'd4)
        sf_top = RANK_WHEEL_HI;

    flush_hit  = 1'b0;
    flush_suit = 2'd0;
    near_flush = 1'b0;
    for (int s = 0; s < 4; s++) begin
      if (suit_cnt[s] >= 4'd5 && !flush_hit) begin
        flush_hit  = 1'b1;
        flush_suit = 2'(s);
      end
      if (suit_cnt[s] == 4'd4) near_flush = 1'b1;
    end

    near_straight = (pop5({pres[ACE_IDX], pres[3:0]}) == 3'd4);
    for (int h = 0; h <= NUM_RANKS - 5; h++)
      if (pop5(pres[h +: 5]) == 3'd4) near_straight = 1'b1;

    cat  = CAT_HIGH;
    kick = '0;
    rest = '0;
    if (sf_top != 4'd0) begin
      cat     = CAT_SF;
      kick[0] = sf_top;
    end else if (sc.quad_r != 4'd0) begin
      cat     = CAT_QUADS;
      rest    = drop_ranks(sc.top_all, sc.quad_r, 4'd0);
      kick[0] = sc.quad_r;
      kick[1] = rest[0];
    end else if (sc.trip_hi != 4'd0 && (sc.trip_lo != 4'd0 || sc.pair_hi != 4'd0)) begin
      cat     = CAT_FULL;
      kick[0] = sc.trip_hi;
      kick[1] = (sc.trip_lo > sc.pair_hi) ? sc.trip_lo : sc.pair_hi;
    end else if (flush_hit) begin
      cat  = CAT_FLUSH;
      kick = sc.top_s[flush_suit];
    end else if (straight_hi != 4'd0) begin
      cat     = CAT_STRAIGHT;
      kick[0] = straight_hi;
    end else if (sc.trip_hi != 4'd0) begin
      cat     = CAT_TRIPS;
      rest    = drop_ranks(sc.top_all, sc.trip_hi, 4'd0);
      kick[0] = sc.trip_hi;
      kick[1] = rest[0];
      kick[2] = rest[1];
    end else if (sc.pair_hi != 4'd0 && sc.pair_lo != 4'd0) begin
      cat     = CAT_TWO_PAIR;
      rest    = drop_ranks(sc.top_all, sc.pair_hi, sc.pair_lo);
      kick[0] = sc.pair_hi;
      kick[1] = sc.pair_lo;
      kick[2] = rest[0];
    end else if (sc.pair_hi != 4'd0) begin
      cat     = CAT_PAIR;
      rest    = drop_ranks(sc.top_all, sc.pair_hi, 4'd0);
      kick[0] = sc.pair_hi;
      kick[1] = rest[0];
      kick[2] = rest[1];
      kick[3] = rest[2];
    end else begin
      kick = sc.top_all;
    end

    fd_n    = near_flush && !flush_hit;
    sd_n    = near_straight && (straight_hi == 4'd0);
    score_n = '0;
    score_n[SCORE_CAT_LSB +: KICKER_W] = cat;
    for (int i = 0; i < 5; i++)
      score_n[SCORE_K0_LSB - KICKER_W*i +: KICKER_W] = kick[i];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      score         <= '0;
      flush_draw    <= 1'b0;
      straight_draw <= 1'b0;
      dup_err       <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      done_q <= (state_q == S_DONE);
      if (state_q == S_FINAL) begin
        score         <= score_n;
        flush_draw    <= fd_n;
        straight_draw <= sd_n;
        dup_err       <= dup_q;
      end
    end
  end

endmodule

// File: tb/tb_hand_evaluator.sv
// tb/tb_hand_evaluator.sv - directed self-checking bench for hand_evaluator
module tb_hand_evaluator;

  localparam logic [1:0] C = 2'd0, H = 2'd1, S = 2'd2, D = 2'd3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [41:0] cards = '0;
  logic        busy, done, flush_draw, straight_draw, dup_err;
  logic [23:0] score;

  int checks = 0;
  int failures = 0;
  int pulses;

  hand_evaluator #(.NUM_CARDS(7), .CARD_W(6)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .cards         (cards),
    .busy          (busy),
    .done          (done),
    .score         (score),
    .flush_draw    (flush_draw),
    .straight_draw (straight_draw),
    .dup_err       (dup_err)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] cd(input logic [3:0] r, input logic [1:0] s);
    return {s, r};
  endfunction

  function automatic logic [41:0] hand(input logic [5:0] c0, c1, c2, c3, c4, c5, c6);
    return {c6, c5, c4, c3, c2, c1, c0};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_hand(input string tag, input logic [41:0] h, input logic [23:0] exp_score,
                          input logic exp_fd, input logic exp_sd, input logic exp_dup,
                          input bit hold);
    int lat;
    @(negedge clk);
    cards = h;
    start = 1'b1;
    @(posedge clk);
    #1;
    if (hold) cards = ~h;
    else      start = 1'b0;
    check({tag, " busy"}, 32'(busy), 32'd1);
    lat = 0;
    while (done !== 1'b1 && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
    start = 1'b0;
    check({tag, " latency"}, lat, 32'd22);
    check({tag, " score"}, 32'(score), 32'(exp_score));
    check({tag, " flush_draw"}, 32'(flush_draw), 32'(exp_fd));
    check({tag, " straight_draw"}, 32'(straight_draw), 32'(exp_sd));
    check({tag, " dup_err"}, 32'(dup_err), 32'(exp_dup));
    check({tag, " busy_at_done"}, 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    check({tag, " done_width"}, 32'(done), 32'd0);
    check({tag, " no_restart"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset score", 32'(score), 32'd0);
    check("reset flags", {29'd0, flush_draw, straight_draw, dup_err}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    run_hand("royal_sf", hand(cd(14,H), cd(13,H), cd(12,H), cd(11,H), cd(10,H), cd(2,C), cd(3,D)),
             24'h8E0000, 1'b0, 1'b0, 1'b0, 1'b0);
    run_hand("wheel", hand(cd(14,C), cd(2,D), cd(3,S), cd(4,H), cd(5,C), cd(9,D), cd(13,D)),
             24'h450000, 1'b0, 1'b0, 1'b0, 1'b0);
    run_hand("two_trips_fh", hand(cd(13,S), cd(13,D), cd(13,H), cd(7,C), cd(7,D), cd(7,S), cd(2,H)),
             24'h6D7000, 1'b0, 1'b0, 1'b0, 1'b1);
    run_hand("three_pairs", hand(cd(14,C), cd(14,D), cd(9,S), cd(9,H), cd(4,C), cd(4,D), cd(12,S)),
             24'h2E9C00, 1'b0, 1'b0, 1'b0, 1'b0);
    run_hand("flush_draw", hand(cd(2,H), cd(5,H), cd(9,H), cd(11,H), cd(13,C), cd(3,C), cd(8,S)),
             24'h0DB985, 1'b1, 1'b0, 1'b0, 1'b0);
    run_hand("dup_sdraw", hand(cd(2,H), cd(2,H), cd(7,C), cd(9,D), cd(11,C), cd(12,S), cd(13,H)),
             24'h0DCB97, 1'b0, 1'b1, 1'b1, 1'b0);
    run_hand("quads", hand(cd(9,C), cd(9,D), cd(9,H), cd(9,S), cd(13,C), cd(2,D), cd(3,H)),
             24'h79D000, 1'b0, 1'b0, 1'b0, 1'b0);
    run_hand("flush", hand(cd(2,S), cd(6,S), cd(9,S), cd(11,S), cd(13,S), cd(14,D), cd(3,C)),
             24'h5DB962, 1'b0, 1'b0, 1'b0, 1'b0);
    run_hand("straight", hand(cd(5,C), cd(6,D), cd(7,H), cd(8,S), cd(9,C), cd(2,D), cd(13,H)),
             24'h490000, 1'b0, 1'b0, 1'b0, 1'b0);
    run_hand("empty_slots", hand(cd(14,C), cd(13,D), cd(12,S), cd(0,C), cd(15,H), cd(1,D), cd(0,S)),
             24'h0EDC00, 1'b0, 1'b0, 1'b0, 1'b0);
    run_hand("pair", hand(cd(8,C), cd(8,D), cd(14,C), cd(13,D), cd(4,S), cd(6,H), cd(2,C)),
             24'h18ED60, 1'b0, 1'b0, 1'b0, 1'b0);
    run_hand("trips", hand(cd(5,C), cd(5,D), cd(5,H), cd(14,C), cd(12,D), cd(8,S), cd(2,C)),
             24'h35EC00, 1'b0, 1'b0, 1'b0, 1'b0);
    run_hand("fh_pair", hand(cd(3,C), cd(3,D), cd(3,H), cd(12,S), cd(12,D), cd(2,C), cd(9,H)),
             24'h63C000, 1'b0, 1'b0, 1'b0, 1'b0);

    @(negedge clk);
    cards = hand(cd(14,C), cd(14,D), cd(9,S), cd(9,H), cd(4,C), cd(4,D), cd(12,S));
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort score", 32'(score), 32'd0);
    check("abort flags", {29'd0, flush_draw, straight_draw, dup_err}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    pulses = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) pulses++;
    end
    check("abort no_done", pulses, 32'd0);
    run_hand("after_abort", hand(cd(14,C), cd(14,D), cd(9,S), cd(9,H), cd(4,C), cd(4,D), cd(12,S)),
             24'h2E9C00, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
